// File: rtl/mealy_1010_detector.sv
// Serial "1010" pattern detector: Mealy FSM with a combinational hit flag.
// OVERLAP selects whether the trailing "10" of a hit seeds the next match.
module mealy_1010_detector #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GOT1   = 2'b01,
        GOT10  = 2'b10,
        GOT101 = 2'b11
    } state_e;

    state_e state_q;
    state_e state_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        out     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = in ? GOT1 : IDLE;
            end
            GOT1: begin
                state_d = in ? GOT1 : GOT10;
            end
            GOT10: begin
                state_d = in ? GOT101 : IDLE;
            end
            GOT101: begin
                // The hit is flagged only while the closing '0' sits on the input.
                out = (in == 1'b0);
                if (in) begin
                    state_d = GOT1;
                end else begin
                    state_d = OVERLAP ? GOT10 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                out     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mealy_1010_detector.sv
// Scoreboard bench for mealy_1010_detector: overlapping and non-overlapping
// instances share one input stream and are checked against a history-based model.
module tb_mealy_1010_detector;

    typedef struct packed {
        logic ov;
        logic no;
    } exp_t;

    logic clk;
    logic reset;
    logic din;
    logic out_ov;
    logic out_no;

    int n_checks = 0;
    int n_fail   = 0;
    int hits_ov  = 0;
    int hits_no  = 0;

    exp_t sb_q[$];
    bit   hist_ov[$];
    bit   hist_no[$];

    mealy_1010_detector #(.OVERLAP(1'b1)) dut_ov (
        .clk  (clk),
        .reset(reset),
        .in   (din),
        .out  (out_ov)
    );

    mealy_1010_detector #(.OVERLAP(1'b0)) dut_no (
        .clk  (clk),
        .reset(reset),
        .in   (din),
        .out  (out_no)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a hit is a '0' arriving right after "101" in the bit history
    // seen since reset (and, without overlap, since the previous hit).
    function automatic bit ends101(input bit h[$]);
        int n;
        n = h.size();
        if (n < 3) return 1'b0;
        return h[n-3] && !h[n-2] && h[n-1];
    endfunction

    task automatic trim(inout bit h[$]);
        while (h.size() > 3) void'(h.pop_front());
    endtask

    // Drives one bit just after an edge, queues the expected flags, and
    // advances the history once the consuming edge has passed.
    task automatic send_bit(input bit b);
        exp_t e;
        e.ov = ends101(hist_ov) && !b;
        e.no = ends101(hist_no) && !b;
        din = b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        hist_ov.push_back(b);
        trim(hist_ov);
        if (e.no) begin
            hist_no.delete();
        end else begin
            hist_no.push_back(b);
            trim(hist_no);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check("out_ov_in_reset", {31'd0, out_ov}, 32'd0);
        check("out_no_in_reset", {31'd0, out_no}, 32'd0);
        hist_ov.delete();
        hist_no.delete();
        #1;
        reset = 1'b1;
    endtask

    task automatic send_stream(input bit bits[$]);
        foreach (bits[i]) send_bit(bits[i]);
    endtask

    // Monitor: the flag is always presented, so compare once per cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_ov", {31'd0, out_ov}, {31'd0, e.ov});
                check("out_no", {31'd0, out_no}, {31'd0, e.no});
                if (out_ov === 1'b1) hits_ov++;
                if (out_no === 1'b1) hits_no++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_ov;
        int base_no;
        bit s_alt[$];
        bit s_one[$];

        s_alt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        s_one = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Held reset with an undriven input, released between edges.
        reset = 1'b0;
        din   = 1'bx;
        repeat (2) begin
            @(negedge clk);
            check("reset_out_ov", {31'd0, out_ov}, 32'd0);
            check("reset_out_no", {31'd0, out_no}, 32'd0);
        end
        din = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Alternating stream: three overlapped hits, two without overlap.
        base_ov = hits_ov;
        base_no = hits_no;
        send_stream(s_alt);
        check("hits_ov_alt", hits_ov - base_ov, 32'd3);
        check("hits_no_alt", hits_no - base_no, 32'd2);

        // Single embedded hit followed by a run of zeros.
        pulse_reset();
        base_ov = hits_ov;
        base_no = hits_no;
        send_stream(s_one);
        check("hits_ov_single", hits_ov - base_ov, 32'd1);
        check("hits_no_single", hits_no - base_no, 32'd1);

        // Reset after "101" kills the pending hit at once and on the next '0'.
        pulse_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        din = 1'b0;
        #1;
        check("pre_reset_hit_ov", {31'd0, out_ov}, 32'd1);
        check("pre_reset_hit_no", {31'd0, out_no}, 32'd1);
        pulse_reset();
        base_ov = hits_ov;
        send_bit(1'b0);
        check("no_hit_after_reset", hits_ov - base_ov, 32'd0);

        // Combinational response: toggle the input inside one cycle in GOT101.
        pulse_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        din = 1'b1;
        #1;
        check("toggle_hi_a", {31'd0, out_ov}, 32'd0);
        din = 1'b0;
        #1;
        check("toggle_lo_ov", {31'd0, out_ov}, 32'd1);
        check("toggle_lo_no", {31'd0, out_no}, 32'd1);
        din = 1'b1;
        #1;
        check("toggle_hi_b", {31'd0, out_ov}, 32'd0);
        send_bit(1'b1);

        // Random stream with a bias toward the pattern and sporadic resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                send_bit(1'b1);
                send_bit(1'b0);
            end else begin
                send_bit(1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
